dmem_responder: RTL and testbench

Data-memory responder for the 5-stage MIPS pipeline: the target end of the MEM-stage load/store interface (`we_dmm`, `alu_outm`, `wd_dmm` in; `rd_dm` out to the MEM/WB register). It holds a word-addressed RAM and inserts a configurable number of wait states per access. It asserts `stall_m`, which the hazard logic ORs into a whole-pipeline freeze until the access completes.

---
 rtl/dmem_responder_if.sv | 20 ++
 rtl/dmem_responder.sv | 106 ++++++++++
 tb/tb_dmem_responder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// MEM-stage load/store bus between the pipeline (master) and the data memory (slave).
interface dmem_responder_if;
  logic        we_dmm;
  logic        re_dmm;
  logic [31:0] alu_outm;
  logic [31:0] wd_dmm;
  logic [31:0] rd_dm;
  logic        stall_m;
  logic        misalign;

  modport master (
    output we_dmm, re_dmm, alu_outm, wd_dmm,
    input  rd_dm, stall_m, misalign
  );

  modport slave (
    input  we_dmm, re_dmm, alu_outm, wd_dmm,
    output rd_dm, stall_m, misalign
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory for the MEM stage with a configurable number of
// wait states per access; stall_m freezes the pipeline until completion.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam int unsigned ADDR_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam bit          ONE_WAIT  = (WAIT_CYCLES == 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        misalign_q, misalign_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic              req;
  logic              aligned;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd_word;
  logic              mem_we;
  logic              stall;
  logic [31:0]       rd_data;
  logic              unused_addr_hi;

  assign req            = bus.we_dmm | bus.re_dmm;
  assign aligned        = (bus.alu_outm[1:0] == 2'b00);
  assign idx            = bus.alu_outm[ADDR_W+1:2];
  assign rd_word        = mem[idx];
  // Upper address bits are ignored so accesses wrap modulo the RAM size.
  assign unused_addr_hi = ^bus.alu_outm[31:ADDR_W+2];

  // Next-state, store-commit and combinational response decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    misalign_d = misalign_q;
    mem_we     = 1'b0;
    stall      = 1'b0;
    rd_data    = '0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (!aligned) begin
            misalign_d = 1'b1;
          end else if (ZERO_WAIT) begin
            rd_data = rd_word;
            mem_we  = bus.we_dmm;
          end else begin
            stall   = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = ONE_WAIT ? S_DONE : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (bus.re_dmm) rd_data = rd_word;
        mem_we = bus.we_dmm;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset overrides the response outputs immediately, independent of state.
  assign bus.stall_m  = stall & rst;
  assign bus.rd_dm    = rst ? rd_data : '0;
  assign bus.misalign = misalign_q;

  // Control state: FSM, wait counter and sticky misalignment flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
    end
  end

  // RAM array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we & rst) mem[idx] <= bus.wd_dmm;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with two wait states, one with zero wait states.
module tb_dmem_responder;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  dmem_responder_if a ();
  dmem_responder_if b ();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Full access on responder A (two wait states), started while A is idle.
  task automatic acc3(input string tag, input logic we, input logic re,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd);
    a.we_dmm = we; a.re_dmm = re; a.alu_outm = addr; a.wd_dmm = wd;
    #1;
    chk({tag, ".c1.stall"}, {31'b0, a.stall_m}, 32'd1);
    chk({tag, ".c1.rd"}, a.rd_dm, 32'd0);
    cyc(); #1;
    chk({tag, ".c2.stall"}, {31'b0, a.stall_m}, 32'd1);
    chk({tag, ".c2.rd"}, a.rd_dm, 32'd0);
    cyc(); #1;
    chk({tag, ".c3.stall"}, {31'b0, a.stall_m}, 32'd0);
    chk({tag, ".c3.rd"}, a.rd_dm, exp_rd);
    cyc();
    a.we_dmm = 1'b0; a.re_dmm = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    a.we_dmm = 1'b1; a.re_dmm = 1'b0; a.alu_outm = 32'h30; a.wd_dmm = 32'h55;
    b.we_dmm = 1'b0; b.re_dmm = 1'b0; b.alu_outm = 32'h0;  b.wd_dmm = 32'h0;

    // Reset held with a store request pending.
    #12;
    chk("rst.stall", {31'b0, a.stall_m}, 32'd0);
    chk("rst.rd", a.rd_dm, 32'd0);
    chk("rst.misalign", {31'b0, a.misalign}, 32'd0);
    chk("rst.b.stall", {31'b0, b.stall_m}, 32'd0);

    // Release: the pending store runs its two wait states.
    rst = 1'b1;
    #1;
    chk("rel.c1.stall", {31'b0, a.stall_m}, 32'd1);
    cyc(); #1;
    chk("rel.c2.stall", {31'b0, a.stall_m}, 32'd1);
    cyc(); #1;
    chk("rel.c3.stall", {31'b0, a.stall_m}, 32'd0);
    cyc();
    a.we_dmm = 1'b0;

    // Store then load.
    acc3("st10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0);
    acc3("ld10", 1'b0, 1'b1, 32'h10, 32'h0, 32'hDEADBEEF);
    acc3("ld30", 1'b0, 1'b1, 32'h30, 32'h0, 32'h55);

    // Zero-wait responder: store then load on consecutive cycles.
    b.we_dmm = 1'b1; b.alu_outm = 32'h4; b.wd_dmm = 32'h12345678;
    #1;
    chk("zw.st.stall", {31'b0, b.stall_m}, 32'd0);
    cyc();
    b.we_dmm = 1'b0; b.re_dmm = 1'b1;
    #1;
    chk("zw.ld.stall", {31'b0, b.stall_m}, 32'd0);
    chk("zw.ld.rd", b.rd_dm, 32'h12345678);
    cyc();
    b.re_dmm = 1'b0;
    #1;
    chk("zw.idle.rd", b.rd_dm, 32'd0);

    // Misaligned load.
    a.re_dmm = 1'b1; a.alu_outm = 32'h2;
    #1;
    chk("mis.stall", {31'b0, a.stall_m}, 32'd0);
    chk("mis.rd", a.rd_dm, 32'd0);
    chk("mis.pre", {31'b0, a.misalign}, 32'd0);
    cyc();
    a.re_dmm = 1'b0;
    #1;
    chk("mis.post", {31'b0, a.misalign}, 32'd1);
    cyc();

    // Address wrap: 0x400 maps onto word 0.
    acc3("st400", 1'b1, 1'b0, 32'h400, 32'hA5A5A5A5, 32'h0);
    acc3("ld0", 1'b0, 1'b1, 32'h0, 32'h0, 32'hA5A5A5A5);

    // Abort in the first wait cycle leaves prior contents.
    acc3("st8", 1'b1, 1'b0, 32'h8, 32'h77, 32'h0);
    a.we_dmm = 1'b1; a.alu_outm = 32'h8; a.wd_dmm = 32'h1;
    #1;
    chk("abt.c1.stall", {31'b0, a.stall_m}, 32'd1);
    cyc();
    a.we_dmm = 1'b0;
    #1;
    chk("abt.c2.stall", {31'b0, a.stall_m}, 32'd0);
    cyc();
    acc3("ld8", 1'b0, 1'b1, 32'h8, 32'h0, 32'h77);

    // Simultaneous load and store returns the pre-write word.
    acc3("st20", 1'b1, 1'b0, 32'h20, 32'h11, 32'h0);
    acc3("ldst20", 1'b1, 1'b1, 32'h20, 32'h22, 32'h11);
    acc3("ld20", 1'b0, 1'b1, 32'h20, 32'h0, 32'h22);
    chk("mis.sticky", {31'b0, a.misalign}, 32'd1);

    // Asynchronous reset mid-access forces outputs low.
    a.we_dmm = 1'b1; a.alu_outm = 32'h40; a.wd_dmm = 32'h9;
    #1;
    chk("arst.pre.stall", {31'b0, a.stall_m}, 32'd1);
    cyc();
    rst = 1'b0;
    #1;
    chk("arst.stall", {31'b0, a.stall_m}, 32'd0);
    chk("arst.misalign", {31'b0, a.misalign}, 32'd0);
    chk("arst.rd", a.rd_dm, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
